// File: rtl/ccip_va_vc_scheduler_if.sv
// AFU TX request / grant / RX response bundle between the AFU-side driver and
// the VC scheduler. The master drives requests and responses; the scheduler
// (slave) returns ready, grants and its credit state.
interface ccip_va_vc_scheduler_if #(
  parameter int CNT_WIDTH = 8
);
  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_type;
  logic [1:0]             req_vc;
  logic                   req_sop;
  logic [1:0]             req_len;
  logic                   grant_valid;
  logic [1:0]             grant_vc;
  logic                   rsp_valid;
  logic [1:0]             rsp_vc;
  logic [3*CNT_WIDTH-1:0] outstanding;
  logic                   underflow_err;

  modport master (
    output req_valid, req_type, req_vc, req_sop, req_len, rsp_valid, rsp_vc,
    input  req_ready, grant_valid, grant_vc, outstanding, underflow_err
  );

  modport slave (
    input  req_valid, req_type, req_vc, req_sop, req_len, rsp_valid, rsp_vc,
    output req_ready, grant_valid, grant_vc, outstanding, underflow_err
  );
endinterface

// File: rtl/ccip_va_vc_scheduler.sv
// CCI-P VC scheduler: resolves VA requests onto VL0/VH0/VH1 with a weighted
// round-robin {VL0,VH0,VL0,VH1}, enforces per-VC outstanding-CL credit,
// locks the VC across multi-CL write bursts and holds fences until every VC
// has drained. Grants are registered one cycle after acceptance.
module ccip_va_vc_scheduler #(
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_WIDTH       = 8
) (
  input logic                      clk,
  input logic                      rst,
  ccip_va_vc_scheduler_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_MCL_LOCK    = 2'd1,
    S_FENCE_DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REQ_RD    = 2'd0,
    REQ_WR    = 2'd1,
    REQ_FENCE = 2'd2,
    REQ_RSVD  = 2'd3
  } req_type_e;

  localparam int CW1 = CNT_WIDTH + 1;

  state_e              state;
  req_type_e           req_t;
  logic [CNT_WIDTH-1:0] cnt [3];
  logic [CNT_WIDTH-1:0] inc [3];
  logic [2:0]          rsp_hit;
  logic [1:0]          rr_ptr;
  logic [1:0]          rr_ptr_nxt;
  logic [1:0]          beats_left;
  logic [1:0]          lock_vc;
  logic [2:0]          k_cls;
  logic [2:0]          cost;
  logic [3:0]          elig;
  logic                all_zero;
  logic                ready;
  logic                accept;
  logic [1:0]          sel_vc;
  logic [1:0]          va_vc;
  logic [1:0]          slot_idx [4];
  logic [1:0]          slot_vc  [4];
  logic                grant_valid_q;
  logic [1:0]          grant_vc_q;
  logic                underflow_q;

  // Weighted pattern: VL0 gets two of every four slots.
  function automatic logic [1:0] pattern_vc(input logic [1:0] slot);
    case (slot)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      2'd2:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  assign req_t    = req_type_e'(bus.req_type);
  assign k_cls    = {1'b0, bus.req_len} + 3'd1;
  assign all_zero = (cnt[0] == '0) && (cnt[1] == '0) && (cnt[2] == '0);
  assign va_vc    = (bus.req_vc == 2'd0) ? 2'd1 : bus.req_vc;

  // Per-VC eligibility from registered counters; index 0 (VA) is never eligible.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 3; i++) begin
      elig[i+1] = ({1'b0, cnt[i]} + CW1'(k_cls)) <= CW1'(MAX_OUTSTANDING);
    end
  end

  // Round-robin scan order starting at the pointer.
  always_comb begin
    for (int s = 0; s < 4; s++) begin
      slot_idx[s] = rr_ptr + 2'(s);
      slot_vc[s]  = pattern_vc(slot_idx[s]);
    end
  end

  // Request decode: readiness, resolved VC, credit cost and next RR pointer.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
    ready      = 1'b0;
    sel_vc     = 2'd1;
    cost       = 3'd0;
    rr_ptr_nxt = rr_ptr;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          case (req_t)
            REQ_RD, REQ_WR: begin
              if (req_t == REQ_WR && !bus.req_sop) begin
                // Continuation beat with no burst open: a VA beat has no VC to go to.
                if (bus.req_vc != 2'd0) begin
                  ready  = elig[bus.req_vc];
                  sel_vc = bus.req_vc;
                end
              end else begin
                cost = k_cls;
                if (bus.req_vc != 2'd0) begin
                  ready  = elig[bus.req_vc];
                  sel_vc = bus.req_vc;
                end else begin
                  for (int s = 0; s < 4; s++) begin
                    if (!ready && elig[slot_vc[s]]) begin
                      ready      = 1'b1;
                      sel_vc     = slot_vc[s];
                      rr_ptr_nxt = slot_idx[s] + 2'd1;
                    end
                  end
                end
              end
            end
            REQ_FENCE: begin
              ready  = all_zero;
              sel_vc = va_vc;
            end
            default: begin
              ready  = 1'b1;
              sel_vc = va_vc;
            end
          endcase
        end
      end
      S_MCL_LOCK: begin
        if (bus.req_valid && req_t == REQ_WR && !bus.req_sop) begin
          ready  = 1'b1;
          sel_vc = lock_vc;
        end
      end
      S_FENCE_DRAIN: begin
        if (bus.req_valid && req_t == REQ_FENCE) begin
          ready  = all_zero;
          sel_vc = va_vc;
        end
      end
      default: ;
    endcase
  end

  assign bus.req_ready = ready && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  // Per-VC credit deltas for this cycle.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      inc[i]     = (accept && sel_vc == 2'(i + 1)) ? CNT_WIDTH'(cost) : '0;
      rsp_hit[i] = bus.rsp_valid && (bus.rsp_vc == 2'(i + 1));
    end
  end

  // Scheduler FSM, RR pointer and registered grant.
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state         <= S_IDLE;
      rr_ptr        <= 2'd0;
      beats_left    <= 2'd0;
      lock_vc       <= 2'd1;
      grant_valid_q <= 1'b0;
      grant_vc_q    <= 2'd0;
    end else begin
      grant_valid_q <= accept;
      if (accept) grant_vc_q <= sel_vc;
      case (state)
        S_IDLE: begin
          if (accept) begin
            rr_ptr <= rr_ptr_nxt;
            if (req_t == REQ_WR && bus.req_sop && bus.req_len != 2'd0) begin
              state      <= S_MCL_LOCK;
              beats_left <= bus.req_len;
              lock_vc    <= sel_vc;
            end
          end else if (bus.req_valid && req_t == REQ_FENCE) begin
            state <= S_FENCE_DRAIN;
          end
        end
        S_MCL_LOCK: begin
          if (accept) begin
            beats_left <= beats_left - 2'd1;
            if (beats_left == 2'd1) state <= S_IDLE;
          end
        end
        S_FENCE_DRAIN: begin
          if (accept) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outstanding-CL counters: charge on accept, release on response, flag underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (rsp_hit[i] && cnt[i] == '0) begin
          underflow_q <= 1'b1;
          cnt[i]      <= cnt[i] + inc[i];
        end else begin
          cnt[i] <= cnt[i] + inc[i] - CNT_WIDTH'(rsp_hit[i]);
        end
      end
    end
  end

  assign bus.grant_valid   = grant_valid_q;
  assign bus.grant_vc      = grant_vc_q;
  assign bus.outstanding   = {cnt[2], cnt[1], cnt[0]};
  assign bus.underflow_err = underflow_q;

endmodule

// File: tb/tb_ccip_va_vc_scheduler.sv
// Directed bench for ccip_va_vc_scheduler: expected grant VCs are queued when
// a request is seen accepted; a monitor pops and compares on every grant.
module tb_ccip_va_vc_scheduler;
  localparam int CW = 8;
  localparam logic [1:0] RD = 2'd0, WR = 2'd1, FN = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ccip_va_vc_scheduler_if #(.CNT_WIDTH(CW)) bus ();

  ccip_va_vc_scheduler #(.MAX_OUTSTANDING(64), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant monitor
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (bus.grant_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL grant_unexpected: got grant vc %0d, expected no grant at %0t", bus.grant_vc, $time);
        end else begin
          e = exp_q.pop_front();
          check("grant_vc", 32'(bus.grant_vc), 32'(e));
        end
      end
    end
  end

  // All driver tasks start and end just after a rising edge.
  task automatic drive(input logic [1:0] t, input logic [1:0] vc, input logic sop, input logic [1:0] len);
    bus.req_valid = 1'b1;
    bus.req_type  = t;
    bus.req_vc    = vc;
    bus.req_sop   = sop;
    bus.req_len   = len;
  endtask

  task automatic wait_accept(input string name, input logic [1:0] exp_vc, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        exp_q.push_back(exp_vc);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL %s: request not accepted within %0d cycles at %0t", name, budget, $time);
    end
  endtask

  task automatic issue(input string name, input logic [1:0] t, input logic [1:0] vc,
                       input logic sop, input logic [1:0] len, input logic [1:0] exp_vc);
    drive(t, vc, sop, len);
    wait_accept(name, exp_vc, 1);
  endtask

  task automatic expect_stall(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_out(input string name, input logic [23:0] exp);
    @(negedge clk);
    check(name, 32'(bus.outstanding), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic rsp_pulse(input logic [1:0] vc);
    bus.rsp_valid = 1'b1;
    bus.rsp_vc    = vc;
    @(posedge clk); #1;
    bus.rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.req_valid = 1'b0;
    bus.rsp_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] t1_exp [5];
    t1_exp = '{2'd1, 2'd2, 2'd1, 2'd3, 2'd1};
    bus.rsp_valid = 1'b0;
    bus.rsp_vc    = 2'd0;
    drive(RD, 2'd0, 1'b0, 2'd0);

    // Reset values, with a request presented during reset
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
    check("rst_grant_vc", 32'(bus.grant_vc), 32'd0);
    check("rst_outstanding", 32'(bus.outstanding), 32'd0);
    check("rst_underflow", 32'(bus.underflow_err), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b0;

    // Weighted round-robin on VA reads
    for (int i = 0; i < 5; i++) issue("va_rr_read", RD, 2'd0, 1'b0, 2'd0, t1_exp[i]);
    check_out("va_rr_counts", 24'h010103);

    // Multi-CL write locks VL0; interleaved read waits for the burst to finish
    do_reset();
    issue("mcl_sop", WR, 2'd0, 1'b1, 2'd3, 2'd1);
    drive(RD, 2'd0, 1'b0, 2'd0);
    expect_stall("mcl_read_stall", 2);
    issue("mcl_beat1", WR, 2'd0, 1'b0, 2'd0, 2'd1);
    drive(RD, 2'd0, 1'b0, 2'd0);
    expect_stall("mcl_read_stall", 1);
    issue("mcl_beat2", WR, 2'd0, 1'b0, 2'd0, 2'd1);
    issue("mcl_beat3", WR, 2'd0, 1'b0, 2'd0, 2'd1);
    check_out("mcl_vl0_count", 24'h000004);
    issue("mcl_read_after", RD, 2'd0, 1'b0, 2'd0, 2'd2);
    check_out("mcl_after_read", 24'h000104);

    // VL0 full: VA skips to VH0, explicit VL0 stalls until one response
    do_reset();
    for (int i = 0; i < 16; i++) issue("fill_vl0", RD, 2'd1, 1'b0, 2'd3, 2'd1);
    check_out("vl0_full_count", 24'h000040);
    issue("va_skip_vl0", RD, 2'd0, 1'b0, 2'd0, 2'd2);
    drive(RD, 2'd1, 1'b0, 2'd0);
    expect_stall("vl0_full_stall", 3);
    bus.rsp_valid = 1'b1;
    bus.rsp_vc    = 2'd1;
    @(negedge clk);
    check("vl0_stall_rsp_cycle", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    bus.rsp_valid = 1'b0;
    wait_accept("vl0_after_rsp", 2'd1, 1);
    check_out("vl0_refill_count", 24'h000140);

    // Fence drains all VCs before it is accepted
    do_reset();
    issue("pre_fence_vh0", RD, 2'd2, 1'b0, 2'd1, 2'd2);
    issue("pre_fence_vl0", RD, 2'd1, 1'b0, 2'd0, 2'd1);
    check_out("pre_fence_counts", 24'h000201);
    drive(FN, 2'd0, 1'b0, 2'd0);
    begin
      logic [1:0] rvc [3];
      rvc = '{2'd2, 2'd2, 2'd1};
      for (int i = 0; i < 3; i++) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_vc    = rvc[i];
        @(negedge clk);
        check("fence_drain_stall", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
      end
    end
    bus.rsp_valid = 1'b0;
    wait_accept("fence_accept", 2'd1, 1);
    check_out("post_fence_counts", 24'h000000);

    // Same-cycle accept and response on VH1; underflow on VH0
    do_reset();
    issue("vh1_fill4", RD, 2'd3, 1'b0, 2'd3, 2'd3);
    issue("vh1_fill1", RD, 2'd3, 1'b0, 2'd0, 2'd3);
    check_out("vh1_count5", 24'h050000);
    drive(RD, 2'd3, 1'b0, 2'd1);
    bus.rsp_valid = 1'b1;
    bus.rsp_vc    = 2'd3;
    wait_accept("vh1_same_cycle", 2'd3, 1);
    bus.rsp_valid = 1'b0;
    check_out("vh1_net_count6", 24'h060000);
    rsp_pulse(2'd2);
    @(negedge clk);
    check("underflow_set", 32'(bus.underflow_err), 32'd1);
    check("underflow_vh0_holds", 32'(bus.outstanding), 32'h060000);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("underflow_sticky", 32'(bus.underflow_err), 32'd1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("underflow_cleared", 32'(bus.underflow_err), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of a burst
    issue("rst_mcl_sop", WR, 2'd0, 1'b1, 2'd3, 2'd1);
    issue("rst_mcl_beat1", WR, 2'd0, 1'b0, 2'd0, 2'd1);
    rst = 1'b1;
    drive(WR, 2'd0, 1'b0, 2'd0);
    @(negedge clk);
    check("rst_mid_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_no_grant", 32'(bus.grant_valid), 32'd0);
    check("rst_mid_counts", 32'(bus.outstanding), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_no_grant_next", 32'(bus.grant_valid), 32'd0);
    @(posedge clk); #1;
    expect_stall("beat_after_rst_stall", 2);
    bus.req_valid = 1'b0;
    issue("rst_ptr_zero", RD, 2'd0, 1'b0, 2'd0, 2'd1);
    check_out("rst_final_counts", 24'h000001);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
